// File: rtl/pad_ctrl_pkg.sv
// Shared definitions for the pad colour control stage: clear FSM states,
// channel count and bit positions inside the colour register, PWM width.
package pad_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    HOLD     = 2'd1,
    WAIT_REL = 2'd2
  } clr_state_t;

  localparam int NUM_CH   = 3;
  localparam int CH_RED   = 0;
  localparam int CH_BLUE  = 1;
  localparam int CH_GREEN = 2;
  localparam int PWM_W    = 4;

  // True when every channel in the vector is set
  function automatic logic all_set(input logic [NUM_CH-1:0] v);
    return &v;
  endfunction

  // True when no channel in the vector is set
  function automatic logic none_set(input logic [NUM_CH-1:0] v);
    return ~|v;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: two-flop synchroniser, debounce counter, debounced
// level and a single-cycle rise strobe that is valid on the edge where the
// debounced level goes from 0 to 1.
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 20000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_stable,
  output logic o_rise
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;
  logic             w_expire;

  // Bring the raw asynchronous button into the clock domain
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
    end
  end

  assign w_expire = (r_cnt == CNT_MAX);

  // Count consecutive disagreeing clocks; accept the new level only after a full run
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else if (r_sync2 == r_stable) begin
      r_cnt <= '0;
    end else if (w_expire) begin
      r_stable <= r_sync2;
      r_cnt    <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_stable = r_stable;
  assign o_rise   = r_sync2 & ~r_stable & w_expire;

endmodule

// File: rtl/pad_color_ctrl.sv
// Pad colour control: three debounced buttons toggle red/blue/green, a long
// hold of all three clears the colour. Define COLOR_PWM_EN to add a 16-step
// PWM dimmer on the colour outputs; without it outputs follow the colour
// register directly.
module pad_color_ctrl
  import pad_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = 20000,
  parameter int unsigned LONG_CYCLES = 1000000,
  parameter int unsigned PWM_DUTY    = 8
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       BTN1,
  input  logic       BTN2,
  input  logic       BTN3,
  output logic       red,
  output logic       blue,
  output logic       green,
  output logic [2:0] press
);

  localparam int HCNT_W = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
  localparam logic [HCNT_W-1:0] HCNT_MAX = HCNT_W'(LONG_CYCLES - 1);

  if (DEB_CYCLES < 2 || LONG_CYCLES < 2 || PWM_DUTY > 16) begin : g_bad_params
    $error("pad_color_ctrl: parameter out of range");
  end

  logic [NUM_CH-1:0] w_btn;
  logic [NUM_CH-1:0] w_stable;
  logic [NUM_CH-1:0] w_rise;
  logic [NUM_CH-1:0] r_press;
  logic [NUM_CH-1:0] r_col;
  logic [HCNT_W-1:0] r_hcnt;
  clr_state_t        r_state;

  assign w_btn[CH_RED]   = BTN1;
  assign w_btn[CH_BLUE]  = BTN2;
  assign w_btn[CH_GREEN] = BTN3;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    btn_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .i_clk    (CLK),
      .i_rst_n  (RST_N),
      .i_btn    (w_btn[g]),
      .o_stable (w_stable[g]),
      .o_rise   (w_rise[g])
    );
  end

  // Register the rise strobes so press pulses carry no combinational path
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_press <= '0;
    end else begin
      r_press <= w_rise;
    end
  end

  // Colour toggling plus the long-hold clear FSM; the clear is written last so it wins
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= RUN;
      r_hcnt  <= '0;
      r_col   <= '0;
    end else begin
      if (r_state != WAIT_REL) begin
        r_col <= r_col ^ w_rise;
      end
      case (r_state)
        RUN: begin
          if (all_set(w_stable)) begin
            r_state <= HOLD;
            r_hcnt  <= '0;
          end
        end
        HOLD: begin
          if (!all_set(w_stable)) begin
            r_state <= RUN;
          end else if (r_hcnt == HCNT_MAX) begin
            r_col   <= '0;
            r_state <= WAIT_REL;
          end else begin
            r_hcnt <= r_hcnt + 1'b1;
          end
        end
        WAIT_REL: begin
          if (none_set(w_stable)) begin
            r_state <= RUN;
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

  assign press = r_press;

`ifdef COLOR_PWM_EN
  localparam logic [PWM_W:0] DUTY = (PWM_W + 1)'(PWM_DUTY);

  logic [PWM_W-1:0] r_pwm_cnt;
  logic             w_pwm_on;

  // Free-running dimmer phase, wraps naturally at 16
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_pwm_cnt <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
    end
  end

  assign w_pwm_on = ({1'b0, r_pwm_cnt} < DUTY);
  assign red      = r_col[CH_RED]   & w_pwm_on;
  assign blue     = r_col[CH_BLUE]  & w_pwm_on;
  assign green    = r_col[CH_GREEN] & w_pwm_on;
`else
  assign red   = r_col[CH_RED];
  assign blue  = r_col[CH_BLUE];
  assign green = r_col[CH_GREEN];
`endif

endmodule

// File: tb/tb_pad_color_ctrl.sv
// Directed bench for pad_color_ctrl with DEB_CYCLES=4, LONG_CYCLES=8 in the
// default (no dimmer) build. Inputs change and outputs are sampled 1ns after
// a rising edge; "edge N" means the Nth rising edge after an input change.
module tb_pad_color_ctrl;

  logic       CLK;
  logic       RST_N;
  logic       BTN1;
  logic       BTN2;
  logic       BTN3;
  logic       red;
  logic       blue;
  logic       green;
  logic [2:0] press;
  logic [2:0] rgb;

  int numCompared;
  int numMismatched;

  pad_color_ctrl #(
    .DEB_CYCLES  (4),
    .LONG_CYCLES (8),
    .PWM_DUTY    (8)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .BTN1  (BTN1),
    .BTN2  (BTN2),
    .BTN3  (BTN3),
    .red   (red),
    .blue  (blue),
    .green (green),
    .press (press)
  );

  assign rgb = {green, blue, red};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic stepClocks(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic b3, input logic b2, input logic b1);
    BTN3 = b3;
    BTN2 = b2;
    BTN1 = b1;
  endtask

  task automatic checkOutput(input string tag, input logic [2:0] observed, input logic [2:0] expected);
    numCompared++;
    assert (observed === expected)
    else begin
      numMismatched++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  initial begin
    numCompared   = 0;
    numMismatched = 0;
    RST_N = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Reset held with buttons toggling
    for (int i = 0; i < 6; i++) begin
      applyStimulus(i[0], ~i[0], i[1]);
      stepClocks(1);
      checkOutput("reset_rgb", rgb, 3'b000);
      checkOutput("reset_press", press, 3'b000);
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    stepClocks(2);
    RST_N = 1'b1;
    stepClocks(10);
    checkOutput("post_reset_rgb", rgb, 3'b000);
    checkOutput("post_reset_press", press, 3'b000);

    // Single press of BTN1: red toggles exactly at edge 6
    $display("[TB] single press");
    applyStimulus(1'b0, 1'b0, 1'b1);
    stepClocks(5);
    checkOutput("press1_edge5_rgb", rgb, 3'b000);
    checkOutput("press1_edge5_press", press, 3'b000);
    stepClocks(1);
    checkOutput("press1_edge6_rgb", rgb, 3'b001);
    checkOutput("press1_edge6_press", press, 3'b001);
    stepClocks(1);
    checkOutput("press1_edge7_press", press, 3'b000);
    checkOutput("press1_edge7_rgb", rgb, 3'b001);
    stepClocks(13);
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      stepClocks(1);
      checkOutput("release1_press", press, 3'b000);
    end
    checkOutput("release1_rgb", rgb, 3'b001);

    // Second press returns red to 0
    applyStimulus(1'b0, 1'b0, 1'b1);
    stepClocks(6);
    checkOutput("press2_rgb", rgb, 3'b000);
    checkOutput("press2_press", press, 3'b001);
    applyStimulus(1'b0, 1'b0, 1'b0);
    stepClocks(8);

    // BTN2 bounce: three 3-clock pulses never get through
    $display("[TB] bounce");
    for (int p = 0; p < 3; p++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
        stepClocks(1);
        checkOutput("bounce_press_hi", press, 3'b000);
      end
      applyStimulus(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
        stepClocks(1);
        checkOutput("bounce_press_lo", press, 3'b000);
      end
    end
    stepClocks(4);
    checkOutput("bounce_press_tail", press, 3'b000);
    checkOutput("bounce_rgb", rgb, 3'b000);

    // A proper BTN2 hold sets blue
    applyStimulus(1'b0, 1'b1, 1'b0);
    stepClocks(5);
    checkOutput("blue_edge5_rgb", rgb, 3'b000);
    stepClocks(1);
    checkOutput("blue_edge6_rgb", rgb, 3'b010);
    checkOutput("blue_edge6_press", press, 3'b010);
    applyStimulus(1'b0, 1'b0, 1'b0);
    stepClocks(8);
    checkOutput("blue_release_rgb", rgb, 3'b010);

    // BTN1 and BTN3 together toggle red and green on the same edge
    $display("[TB] simultaneous");
    applyStimulus(1'b1, 1'b0, 1'b1);
    stepClocks(5);
    checkOutput("simul_edge5_rgb", rgb, 3'b010);
    stepClocks(1);
    checkOutput("simul_edge6_rgb", rgb, 3'b111);
    checkOutput("simul_edge6_press", press, 3'b101);
    applyStimulus(1'b0, 1'b0, 1'b0);
    stepClocks(8);
    checkOutput("simul_release_rgb", rgb, 3'b111);

    // Reset mid-operation clears outputs without waiting for a clock
    RST_N = 1'b0;
    #1;
    checkOutput("midreset_rgb", rgb, 3'b000);
    stepClocks(2);
    RST_N = 1'b1;
    stepClocks(3);
    checkOutput("midreset_after_rgb", rgb, 3'b000);

    // Long hold of all three: toggle to 111 at edge 6, HOLD at edge 7, clear at edge 15
    $display("[TB] clear");
    applyStimulus(1'b1, 1'b1, 1'b1);
    stepClocks(6);
    checkOutput("clear_toggle_rgb", rgb, 3'b111);
    checkOutput("clear_toggle_press", press, 3'b111);
    stepClocks(8);
    checkOutput("clear_edge14_rgb", rgb, 3'b111);
    stepClocks(1);
    checkOutput("clear_edge15_rgb", rgb, 3'b000);
    stepClocks(10);
    checkOutput("clear_held_rgb", rgb, 3'b000);

    // In WAIT_REL a re-press still pulses but does not toggle the colour
    applyStimulus(1'b1, 1'b1, 1'b0);
    stepClocks(8);
    applyStimulus(1'b1, 1'b1, 1'b1);
    stepClocks(6);
    checkOutput("waitrel_press", press, 3'b001);
    checkOutput("waitrel_rgb", rgb, 3'b000);

    // Release everything, back to RUN, then BTN1 works again
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      stepClocks(1);
      checkOutput("clear_release_press", press, 3'b000);
    end
    checkOutput("clear_release_rgb", rgb, 3'b000);
    applyStimulus(1'b0, 1'b0, 1'b1);
    stepClocks(6);
    checkOutput("after_clear_rgb", rgb, 3'b001);
    checkOutput("after_clear_press", press, 3'b001);
    applyStimulus(1'b0, 1'b0, 1'b0);
    stepClocks(8);
    checkOutput("final_rgb", rgb, 3'b001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
